ysyx_22041412_gpr_rd: RTL and testbench
=======================================

# ysyx_22041412_gpr_rd

Read side of the NPC general-purpose register file. Holds NREG×XLEN architectural registers, takes one write per cycle from write-back, and serves paired source-operand reads (rs1, rs2) to decode over a valid/ready request/response handshake. Every response is registered, and one response is buffered so that a stalled consumer never loses data.

## Interface
- XLEN, 64, register width in bits
- NREG, 32, number of registers; x0 is hardwired to zero
- AW, 5, register address width; must equal log2(NREG)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wen  in  1  write enable from write-back
- waddr  in  AW  write register index
- wdata  in  XLEN  write data
- req_valid  in  1  read request valid
- req_ready  out  1  read request can be accepted this cycle
- rs1  in  AW  source register 1 index
- rs2  in  AW  source register 2 index
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rdata1  out  XLEN  value of rs1
- rdata2  out  XLEN  value of rs2

## Operation
- Storage: NREG entries, all cleared to 0 on rst.
- Write: at the posedge with wen=1 and waddr≠0, entry[waddr] ← wdata. Writes to x0 are dropped.
- Request accept: a request is accepted when req_valid && req_ready.
- req_ready = !rsp_valid || rsp_ready. This is combinational, and a new request is accepted in the same cycle the old response drains.
- On accept, rdata1/rdata2 load from entry[rs1]/entry[rs2] and rsp_valid is set to 1.
- Index 0 always reads 0, regardless of wen or bypass.
- Response handshake: rsp_valid clears when rsp_ready=1 and no new request is accepted that cycle.
- While rsp_valid && !rsp_ready, rdata1/rdata2 are frozen. A later write to the same register does not update a held response.
- States:
  - EMPTY (rsp_valid=0) → FULL on accept.
  - FULL → FULL on accept while draining, or on stall.
  - FULL → EMPTY when draining with no accept.
- Simultaneous write and read of the same index in the accept cycle is resolved by the configuration below.
- rst mid-transaction: rsp_valid → 0, rdata1/rdata2 → 0, and all entries → 0 at that edge. An in-flight response is discarded.

## Timing
- Read latency: 1 cycle. Request accepted at edge N; response is visible after edge N with rsp_valid=1.
- Write-to-storage latency: 1 cycle. A read accepted at edge N+1 or later sees a write done at edge N.
- Throughput: 1 request per cycle while rsp_ready=1.
- Reset values: rsp_valid=0, rdata1=0, rdata2=0. req_ready=1 after reset, since it follows from rsp_valid=0.
- No combinational path from req_valid or rs1/rs2 to rdata1/rdata2.
- req_ready depends combinationally on rsp_ready only.

## Configuration
- YSYX_22041412_GPR_BYPASS_EN defined: write-to-read forwarding is enabled.
  - If the accept cycle has wen=1, waddr≠0, and waddr equals rs1 (or rs2), the corresponding rdata loads wdata.
  - Both operands can forward from the same write.
- Not defined: read-before-write. A same-cycle read returns the pre-write entry value, and the new value is visible from the next accepted request.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then read: assert rst 2 cycles, then request rs1=5, rs2=0. Expected: req_ready=1, response after 1 cycle, rdata1=0, rdata2=0.
- Write then read: write x3=0xDEAD_BEEF_0000_0001 at edge N, then request rs1=3, rs2=3 at edge N+1. Expected: both rdata=0xDEAD_BEEF_0000_0001.
- x0 protection: write x0=0xFFFF_FFFF_FFFF_FFFF, then read rs1=0. Expected: rdata1=0.
- Same-cycle hazard: x7 holds 0x11; write x7=0x22 in the same cycle a request for rs1=7 is accepted. Expected: rdata1=0x22 with the macro defined, 0x11 without it.
- Backpressure: hold rsp_ready=0 for 3 cycles after a response for x3 is held, writing x3=0x99 meanwhile. Expected:
  - req_ready=0 throughout.
  - rdata1 stays at the old value.
  - Raising rsp_ready together with a pending req_valid gives req_ready=1, a same-cycle accept, and the next response rdata1=0x99.
- Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=0. Expected: next cycle rsp_valid=0, rdata=0, and a read of x3 returns 0.

Source files
------------

// File: rtl/ysyx_22041412_gpr_rd.sv
// Purpose: NPC register file with a registered, stall-safe rs1/rs2 read port; x0 reads zero.
// Latency: 1 cycle from request accept to response; writes visible to reads accepted the next cycle.
// Backpressure: one response buffer; req_ready = !rsp_valid || rsp_ready. Define YSYX_22041412_GPR_BYPASS_EN for same-cycle write forwarding.
module ysyx_22041412_gpr_rd #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rd1_nxt;
    logic [XLEN-1:0] rd2_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL: begin
                if (accept) begin
                    state_nxt = FULL;
                end else if (rsp_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Outputs: req_ready only sees the buffer state and rsp_ready
    always_comb begin
        rsp_valid = (state == FULL);
        req_ready = !rsp_valid || rsp_ready;
        accept    = req_valid && req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rd1_nxt = regs[rs1];
        rd2_nxt = regs[rs2];
`ifdef YSYX_22041412_GPR_BYPASS_EN
        if (wen && (waddr == rs1)) rd1_nxt = wdata;
        if (wen && (waddr == rs2)) rd2_nxt = wdata;
`endif
        // Last so x0 wins over any forwarded value
        if (rs1 == '0) rd1_nxt = '0;
        if (rs2 == '0) rd2_nxt = '0;
    end

    // Response data only moves on accept, so a stalled response is frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (accept) begin
            rdata1 <= rd1_nxt;
            rdata2 <= rd2_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_gpr_rd.sv
// Scoreboarded bench for ysyx_22041412_gpr_rd: directed scenarios followed by random traffic.
module tb_ysyx_22041412_gpr_rd;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wen = 1'b0;
    logic [AW-1:0]   waddr = '0;
    logic [XLEN-1:0] wdata = '0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [AW-1:0]   rs1 = '0;
    logic [AW-1:0]   rs2 = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;

    always #5 clk = ~clk;

    ysyx_22041412_gpr_rd #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .req_valid(req_valid), .req_ready(req_ready), .rs1(rs1), .rs2(rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata1(rdata1), .rdata2(rdata2)
    );

    // Reference model: architectural register contents plus expected responses in order
    logic [XLEN-1:0]   ref_regs [NREG];
    bit                model_full = 1'b0;
    logic [2*XLEN-1:0] exp_q [$];
    int                n_checks = 0;
    int                n_pass = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    endtask

    function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
`ifdef YSYX_22041412_GPR_BYPASS_EN
        if (wen && waddr == idx) return wdata;
`endif
        return ref_regs[idx];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (ref_regs[i]) ref_regs[i] = '0;
            model_full = 1'b0;
            exp_q.delete();
        end else begin
            bit acc;
            acc = req_valid && (!model_full || rsp_ready);
            if (acc) exp_q.push_back({ref_read(rs2), ref_read(rs1)});
            if (wen && waddr != 0) ref_regs[waddr] = wdata;
            if (acc) model_full = 1'b1;
            else if (rsp_ready) model_full = 1'b0;
        end
    end

    // Monitor: compare whatever the DUT presents, retire on handshake at the coming edge
    always @(negedge clk) begin
        if (!rst) begin
            check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_q.size() != 0});
            if (rsp_valid && exp_q.size() != 0) begin
                check("rdata1", rdata1, exp_q[0][XLEN-1:0]);
                check("rdata2", rdata2, exp_q[0][2*XLEN-1:XLEN]);
            end
            if (rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [XLEN-1:0] wd, input logic rv, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic rr);
        @(posedge clk);
        #2;
        rst = r; wen = w; waddr = wa; wdata = wd;
        req_valid = rv; rs1 = a1; rs2 = a2; rsp_ready = rr;
        #1;
        if (!r) check("req_ready", {63'd0, req_ready}, {63'd0, !model_full || rsp_ready});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rdata1"}, rdata1, 64'd0);
        check({tag, "_rdata2"}, rdata2, 64'd0);
        check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        // Reset then read x5/x0
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_reset_state("reset");
        drive(0, 0, 0, 0, 1, 5, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Write x3 then read it on both ports
        drive(0, 1, 3, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 3, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // x0 write is dropped
        drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Same-cycle write/read of x7
        drive(0, 1, 7, 64'h11, 0, 0, 0, 1);
        drive(0, 1, 7, 64'h22, 1, 7, 7, 1);
        drive(0, 0, 0, 0, 1, 7, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Backpressure: held x3 response must not pick up the new write
        drive(0, 0, 0, 0, 1, 3, 0, 1);
        drive(0, 1, 3, 64'h99, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a response is stalled
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_reset_state("midreset");
        drive(0, 0, 0, 0, 1, 3, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Random traffic with small index range to provoke hazards
        repeat (3000) begin
            drive(($urandom_range(0, 499) == 0), $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
        end

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
